// File: rtl/udp_hdr_inserter.sv
// udp_hdr_inserter
// Captures one payload packet from the socket packetiser into a byte buffer,
// then emits an 8-byte UDP header (src, dst, length, zero checksum) followed by
// the payload as a byte stream with valid/ready back-pressure.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_src_port/dst_port    UDP ports, latched at the packet handshake
//   s_udp_pack_valid/ready   packet-length handshake, s_udp_tx_len qualifies it
//   s_udp_tx_start/tx_dat    gap-free payload dump, start marks the first byte
//   m_tdata/tvalid/tlast     output byte stream, m_tready is back-pressure
//   pkt_cnt, drop_cnt        wrapping counters of sent / dropped datagrams
module udp_hdr_inserter #(
    parameter int BUF_AW      = 13,
    parameter int MAX_PAYLOAD = 8100,
    parameter int START_TO    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    input  logic        s_udp_pack_valid,
    output logic        s_udp_pack_ready,
    input  logic [15:0] s_udp_tx_len,
    input  logic        s_udp_tx_start,
    input  logic [7:0]  s_udp_tx_dat,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT_START, CAPTURE, HDR, PAY} state_t;

    state_t state, state_nxt;

    logic [15:0]       len_q, src_q, dst_q, to_cnt, wcnt, cap_idx;
    logic              bad_q;
    logic [2:0]        hcnt;
    logic [BUF_AW-1:0] rptr, raddr, waddr;
    logic [7:0]        mem [2**BUF_AW];
    logic [7:0]        rd_q, hdr_byte;
    logic [15:0]       udp_len;

    logic hs, cap_we, cap_last, mem_we, timeout, out_free, hdr_ld, pay_ld, done, drop;

    assign hs       = (state == IDLE) && s_udp_pack_valid && s_udp_pack_ready;
    assign cap_we   = ((state == WAIT_START) && s_udp_tx_start) || (state == CAPTURE);
    assign cap_idx  = (state == WAIT_START) ? 16'd0 : wcnt;
    // len==0 has no "byte len-1"; the start byte alone closes the packet.
    assign cap_last = (len_q == 16'd0) || (cap_idx == len_q - 16'd1);
    // Bad packets are consumed but only the first MAX_PAYLOAD bytes touch the buffer.
    assign mem_we   = cap_we && (32'(cap_idx) < MAX_PAYLOAD);
    assign waddr    = (32'(cap_idx) >= 2**BUF_AW) ? '1 : cap_idx[BUF_AW-1:0];
    assign timeout  = (state == WAIT_START) && !s_udp_tx_start &&
                      (to_cnt == 16'(START_TO - 1));
    assign drop     = timeout || (cap_we && cap_last && bad_q);

    // Output register may be refilled when empty or being drained this cycle.
    assign out_free = !m_tvalid || m_tready;
    assign hdr_ld   = (state == HDR) && out_free;
    assign pay_ld   = (state == PAY) && out_free && !m_tlast;
    assign done     = (state == PAY) && m_tvalid && m_tready && m_tlast;

    // Read address runs one ahead when a payload byte is consumed, so rd_q
    // always holds buf[rptr] and payload bytes stay back-to-back.
    assign raddr    = pay_ld ? rptr + 1'b1 : rptr;
    assign udp_len  = len_q + 16'd8;

    always_comb begin
        hdr_byte = 8'h00;
        case (hcnt)
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = udp_len[15:8];
            3'd5:    hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (hs) state_nxt = WAIT_START;
            WAIT_START: begin
                if (s_udp_tx_start) begin
                    if (cap_last) state_nxt = bad_q ? IDLE : HDR;
                    else          state_nxt = CAPTURE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE:    if (cap_last) state_nxt = bad_q ? IDLE : HDR;
            HDR:        if (hdr_ld && hcnt == 3'd7) state_nxt = PAY;
            PAY:        if (done) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_udp_pack_ready <= 1'b0;
            len_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            bad_q    <= 1'b0;
            to_cnt   <= '0;
            wcnt     <= '0;
            hcnt     <= '0;
            rptr     <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            s_udp_pack_ready <= (state == IDLE) && !hs;
            if (hs) begin
                len_q  <= s_udp_tx_len;
                src_q  <= cfg_src_port;
                dst_q  <= cfg_dst_port;
                bad_q  <= (s_udp_tx_len == 16'd0) || (32'(s_udp_tx_len) > MAX_PAYLOAD);
                to_cnt <= '0;
            end
            if (state == WAIT_START) to_cnt <= to_cnt + 16'd1;
            if (cap_we) wcnt <= cap_idx + 16'd1;
            if (drop) drop_cnt <= drop_cnt + 16'd1;
            if (state == IDLE) begin
                hcnt <= '0;
                rptr <= '0;
            end
            if (hdr_ld) begin
                m_tdata  <= hdr_byte;
                m_tvalid <= 1'b1;
                m_tlast  <= 1'b0;
                hcnt     <= hcnt + 3'd1;
            end
            if (pay_ld) begin
                m_tdata  <= rd_q;
                m_tvalid <= 1'b1;
                m_tlast  <= (16'(rptr) == len_q - 16'd1);
                rptr     <= rptr + 1'b1;
            end
            if (done) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                pkt_cnt  <= pkt_cnt + 16'd1;
            end
        end
    end

    // Payload buffer: plain synchronous RAM, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr] <= s_udp_tx_dat;
        rd_q <= mem[raddr];
    end

endmodule

// File: tb/tb_udp_hdr_inserter.sv
module tb_udp_hdr_inserter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_src_port, cfg_dst_port, s_udp_tx_len;
    logic        s_udp_pack_valid, s_udp_pack_ready, s_udp_tx_start;
    logic [7:0]  s_udp_tx_dat, m_tdata;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] pkt_cnt, drop_cnt;

    always #5 clk = ~clk;

    udp_hdr_inserter dut (
        .clk(clk), .rst(rst),
        .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
        .s_udp_pack_valid(s_udp_pack_valid), .s_udp_pack_ready(s_udp_pack_ready),
        .s_udp_tx_len(s_udp_tx_len), .s_udp_tx_start(s_udp_tx_start),
        .s_udp_tx_dat(s_udp_tx_dat),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        int         len;
        logic [15:0] src, dst;
        logic [7:0]  base, step;
        logic [15:0] lf;     // hand-computed UDP length field
    } vec_t;

    int n_pass = 0, n_total = 0;
    int cyc = 0, vcount = 0, first_v = -1, stall_err = 0, stall_seen = 0;
    int rdy_mode = 0;        // 0: tready held high, 1: toggling
    logic [7:0] q_dat[$];
    logic       q_last[$];
    logic       prev_stall = 1'b0, prev_v = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // Output monitor: drives tready, records transfers, checks stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rdy_mode == 1) m_tready = ~m_tready;
        else               m_tready = 1'b1;
        if (prev_stall) begin
            stall_seen++;
            if (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l) stall_err++;
        end
        if (m_tvalid && !prev_v) first_v = cyc;
        if (m_tvalid) vcount++;
        if (m_tvalid && m_tready) begin
            q_dat.push_back(m_tdata);
            q_last.push_back(m_tlast);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_v = m_tvalid;
        prev_d = m_tdata;
        prev_l = m_tlast;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] pb(input logic [7:0] base, input logic [7:0] step, input int i);
        return base + 8'(int'(step) * i) + 8'(i >> 8);
    endfunction

    task automatic offer(input logic [15:0] len, input logic [15:0] src, input logic [15:0] dst);
        int k;
        cfg_src_port = src;
        cfg_dst_port = dst;
        s_udp_tx_len = len;
        s_udp_pack_valid = 1'b1;
        for (k = 0; k < 50 && !s_udp_pack_ready; k++) tick();
        if (!s_udp_pack_ready) chk("handshake ready", 32'(s_udp_pack_ready), 32'd1);
        tick();
        s_udp_pack_valid = 1'b0;
        s_udp_tx_len = 16'hDEAD;
        cfg_src_port = ~src;     // must not leak into the current datagram
        cfg_dst_port = ~dst;
    endtask

    task automatic dump(input int n, input logic [7:0] base, input logic [7:0] step,
                        input int delay, output int lc);
        lc = cyc;
        repeat (delay) tick();
        for (int i = 0; i < n; i++) begin
            s_udp_tx_start = (i == 0);
            s_udp_tx_dat = pb(base, step, i);
            lc = cyc;
            tick();
        end
        s_udp_tx_start = 1'b0;
        s_udp_tx_dat = 8'h00;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && pkt_cnt != 16'(target); k++) tick();
        chk("pkt_cnt", 32'(pkt_cnt), 32'(target));
        chk("tvalid after tlast", 32'(m_tvalid), 32'd0);
    endtask

    task automatic check_stream(input int si, input vec_t v, input string nm);
        int n, err, lerr, bad_i;
        logic [7:0] e, bad_a, bad_e;
        n = q_dat.size() - si;
        err = 0; lerr = 0; bad_i = -1; bad_a = 0; bad_e = 0;
        chk({nm, " byte count"}, 32'(n), 32'(v.len + 8));
        for (int i = 0; i < n && i < v.len + 8; i++) begin
            case (i)
                0: e = v.src[15:8];
                1: e = v.src[7:0];
                2: e = v.dst[15:8];
                3: e = v.dst[7:0];
                4: e = v.lf[15:8];
                5: e = v.lf[7:0];
                6, 7: e = 8'h00;
                default: e = pb(v.base, v.step, i - 8);
            endcase
            if (q_dat[si+i] !== e) begin
                if (bad_i < 0) begin bad_i = i; bad_a = q_dat[si+i]; bad_e = e; end
                err++;
            end
            if (q_last[si+i] !== (i == v.len + 7)) lerr++;
        end
        if (err != 0) $display("FAIL %s first bad byte %0d: got %0h expected %0h", nm, bad_i, bad_a, bad_e);
        chk({nm, " bad bytes"}, 32'(err), 32'd0);
        chk({nm, " tlast placement errors"}, 32'(lerr), 32'd0);
        if (n >= 6) chk({nm, " length field"}, {16'h0, q_dat[si+4], q_dat[si+5]}, {16'h0, v.lf});
    endtask

    task automatic run_vec(input vec_t v, input int target, input string nm);
        int si, lc;
        si = q_dat.size();
        first_v = -1;
        offer(16'(v.len), v.src, v.dst);
        dump(v.len, v.base, v.step, 3, lc);
        wait_done(target, 40000);
        check_stream(si, v, nm);
        chk({nm, " hdr latency ok"}, 32'(first_v >= 0 && first_v - lc <= 2), 32'd1);
    endtask

    vec_t tbl[4];
    vec_t big, v2, v3, v100;
    int exp_pkt, vbase, lc, si;

    initial begin
        tbl[0] = '{len: 4,  src: 16'h1234, dst: 16'h5678, base: 8'hAA, step: 8'h11, lf: 16'h000C};
        tbl[1] = '{len: 1,  src: 16'h0001, dst: 16'hFFFF, base: 8'h5A, step: 8'h00, lf: 16'h0009};
        tbl[2] = '{len: 2,  src: 16'hABCD, dst: 16'h0035, base: 8'h10, step: 8'h01, lf: 16'h000A};
        tbl[3] = '{len: 17, src: 16'h8000, dst: 16'h00FF, base: 8'hF0, step: 8'h13, lf: 16'h0019};
        big  = '{len: 8100, src: 16'hC000, dst: 16'h0044, base: 8'h03, step: 8'h07, lf: 16'h1FAC};
        v2   = '{len: 2,   src: 16'h4000, dst: 16'h4001, base: 8'hE0, step: 8'h05, lf: 16'h000A};
        v100 = '{len: 100, src: 16'h0BAD, dst: 16'hF00D, base: 8'h21, step: 8'h03, lf: 16'h006C};
        v3   = '{len: 3,   src: 16'h0102, dst: 16'h0304, base: 8'h77, step: 8'h01, lf: 16'h000B};

        rst = 1'b0;
        cfg_src_port = 0; cfg_dst_port = 0; s_udp_tx_len = 0;
        s_udp_pack_valid = 0; s_udp_tx_start = 0; s_udp_tx_dat = 0;
        repeat (3) tick();
        chk("reset pack_ready", 32'(s_udp_pack_ready), 32'd0);
        chk("reset tvalid", 32'(m_tvalid), 32'd0);
        chk("reset tlast", 32'(m_tlast), 32'd0);
        chk("reset tdata", 32'(m_tdata), 32'd0);
        chk("reset pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        repeat (2) tick();
        chk("ready after reset", 32'(s_udp_pack_ready), 32'd1);

        // Short datagrams with tready held high.
        exp_pkt = 0;
        for (int i = 0; i < 4; i++) begin
            exp_pkt++;
            run_vec(tbl[i], exp_pkt, $sformatf("vec%0d", i));
        end

        // Maximum payload with tready toggling every cycle.
        rdy_mode = 1;
        stall_err = 0; stall_seen = 0;
        exp_pkt++;
        run_vec(big, exp_pkt, "max payload");
        chk("stall stability errors", 32'(stall_err), 32'd0);
        chk("stalls exercised", 32'(stall_seen > 100), 32'd1);
        rdy_mode = 0;
        repeat (3) tick();

        // len=0 and len=MAX+1 are consumed and dropped without output.
        vbase = vcount;
        offer(16'd0, 16'h1111, 16'h2222);
        dump(1, 8'h99, 8'h01, 2, lc);
        repeat (80) tick();
        offer(16'd8101, 16'h3333, 16'h4444);
        dump(8101, 8'h01, 8'h01, 2, lc);
        repeat (5) tick();
        chk("drops: no tvalid cycles", 32'(vcount - vbase), 32'd0);
        chk("drop_cnt after bad lens", 32'(drop_cnt), 32'd2);
        chk("pkt_cnt unchanged by drops", 32'(pkt_cnt), 32'(exp_pkt));
        chk("ready after drops", 32'(s_udp_pack_ready), 32'd1);

        // Handshake with no tx_start: abort after START_TO cycles.
        offer(16'd2, 16'h5555, 16'h6666);
        repeat (60) tick();
        chk("no drop before timeout", 32'(drop_cnt), 32'd2);
        repeat (10) tick();
        chk("drop_cnt after timeout", 32'(drop_cnt), 32'd3);
        chk("ready after timeout", 32'(s_udp_pack_ready), 32'd1);
        exp_pkt++;
        run_vec(v2, exp_pkt, "after timeout");

        // Reset in the middle of the payload phase.
        si = q_dat.size();
        offer(16'd100, v100.src, v100.dst);
        dump(100, v100.base, v100.step, 3, lc);
        for (int k = 0; k < 2000 && q_dat.size() < si + 30; k++) tick();
        chk("mid-PAY reached", 32'(q_dat.size() >= si + 30), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid reset tvalid", 32'(m_tvalid), 32'd0);
        chk("mid reset tlast", 32'(m_tlast), 32'd0);
        chk("mid reset pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("mid reset drop_cnt", 32'(drop_cnt), 32'd0);
        tick();
        rst = 1'b1;
        run_vec(v3, 1, "after mid reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/udp_hdr_inserter.md
Name: udp_hdr_inserter

Overview:
- Sits directly downstream of the socket packetiser.
- Accepts one payload packet at a time over the packetiser's UDP handshake (pack_valid/pack_ready, tx_len, tx_start, tx_dat) and stores it in an internal byte buffer.
- Prepends an 8-byte UDP header (ports, length, zero checksum) and streams the result byte-wise to the IP/MAC stage over an AXI-stream-style valid/ready interface.
- Decouples the packetiser's fixed-rate byte dump from MAC back-pressure.

Parameters:
- BUF_AW, 13, payload buffer address width; depth 2^BUF_AW bytes.
- MAX_PAYLOAD, 8100, largest accepted payload in bytes; must be ≤ 2^BUF_AW.
- START_TO, 64, cycles allowed from handshake to tx_start before the packet is aborted.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-low.
- cfg_src_port  in  16  UDP source port; sampled at handshake.
- cfg_dst_port  in  16  UDP destination port; sampled at handshake.
- s_udp_pack_valid  in  1  packet length offered.
- s_udp_pack_ready  out  1  block can accept a packet.
- s_udp_tx_len  in  16  payload length; qualified by valid.
- s_udp_tx_start  in  1  one-cycle pulse coinciding with the first payload byte.
- s_udp_tx_dat  in  8  payload byte.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  output byte valid.
- m_tlast  out  1  last byte of the datagram.
- m_tready  in  1  downstream accepts the byte.
- pkt_cnt  out  16  datagrams fully sent; wraps.
- drop_cnt  out  16  packets dropped; wraps.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; s_udp_pack_ready=0; m_tvalid=0; m_tlast=0; m_tdata=0; pkt_cnt=0; drop_cnt=0. Release is synchronous to clk.
- IDLE: s_udp_pack_ready=1 (registered, so it rises 1 cycle after entry). When valid&ready, latch len, src and dst ports. Ready drops the next cycle. Go to WAIT_START.
- Length check at handshake: bad = (len==0) or (len>MAX_PAYLOAD). A bad packet is still consumed so the upstream dump completes, but nothing is emitted.
- WAIT_START: count cycles. On s_udp_tx_start, the byte present that cycle is written to buf[0]; go to CAPTURE. If START_TO cycles elapse with no start: drop_cnt+1, return to IDLE.
- CAPTURE: one byte per cycle, gap-free, written to buf[1..len-1]. The write pointer runs 0..len-1. After byte len-1 is written: bad → drop_cnt+1, go to IDLE; otherwise go to HDR. A bad packet is counted as written but not stored beyond MAX_PAYLOAD, and the pointer saturates at the buffer top.
- Any s_udp_tx_start during CAPTURE is ignored. Extra bytes after len are ignored.
- HDR: emit 8 bytes: src_hi, src_lo, dst_hi, dst_lo, L_hi, L_lo, 0x00, 0x00, where L = len+8 in 16-bit arithmetic (len ≤ MAX_PAYLOAD, so no overflow).
- PAY: emit buf[0..len-1]. A registered read yields 1-cycle read latency; it must be hidden by prefetch so bytes stay back-to-back while m_tready=1.
- Output handshake:
  - A byte transfers on m_tvalid&m_tready.
  - m_tdata, m_tvalid and m_tlast stay stable while m_tvalid&!m_tready.
  - m_tvalid never drops mid-datagram except after tlast.
  - m_tlast=1 only on payload byte len-1.
- On the tlast transfer: pkt_cnt+1, go to IDLE. m_tvalid=0 the following cycle.
- Minimum latency: first header byte valid ≤ 2 cycles after the last payload byte is captured.
- Next handshake is possible 1 cycle after returning to IDLE. No overlap of capture and emission.
- Counters wrap 0xFFFF→0x0000.
- cfg port changes after the handshake do not affect the current datagram.
- Reset mid-packet: everything returns to reset values immediately; the partial datagram is lost with no tlast. Downstream must discard it.

Test Plan:
- len=4, ports 0x1234/0x5678, bytes AA BB CC DD, tready=1 → stream 12 34 56 78 00 0C 00 00 AA BB CC DD; tlast on DD; pkt_cnt=1.
- len=1 → 9 bytes total; length field 0x0009; tlast on the single payload byte.
- len=8100, tready toggling 1/0 every cycle → 8108 bytes, payload order intact, data held stable during stalls, length field 0x1FAC.
- len=0 offered, and separately len=8101 with 8101 bytes dumped → no m_tvalid activity; drop_cnt=2; ready returns high afterwards.
- Handshake with no tx_start for 64 cycles → drop_cnt+1, ready high again; a following valid len=2 packet emits normally.
- rst pulsed low during PAY of a len=100 packet → m_tvalid=0 immediately; counters=0; next packet sent correctly.
